// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the MIPS32 pipeline sequencing controller and the ID decoder.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } ctrl_state_e;

    // Primary opcode field values shared with the ID-stage decoder.
    localparam logic [5:0]  RTYPE = 6'h00;
    localparam logic [5:0]  LW    = 6'h23;
    localparam logic [5:0]  SW    = 6'h2B;
    localparam logic [5:0]  BEQ   = 6'h04;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    localparam int          DEFAULT_TIMEOUT = 16;
    localparam int          REG_W           = 5;
    localparam logic [REG_W-1:0] REG_ZERO   = '0;

    function automatic logic is_memop(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and taken-branch evaluation for the pipeline controller.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             mem_read_ex,
    input  logic [REG_W-1:0] rt_ex,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             branch_mem,
    input  logic             zero_mem,
    output logic             loaduse,
    output logic             taken
);

    // $zero never creates a dependency, so a load targeting it cannot stall.
    assign loaduse = mem_read_ex & (rt_ex != REG_ZERO) &
                     ((rt_ex == rs_id) | (rt_ex == rt_id));
    assign taken   = branch_mem & zero_mem;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes, dmem waits with timeout.
// Optional perf counters (stall_cycles, flush_count) built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int CNT_W          = 5,
    parameter int PERF_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_EX,
    input  logic [REG_W-1:0] Rt_EX,
    input  logic [REG_W-1:0] Rs_ID,
    input  logic [REG_W-1:0] Rt_ID,
    input  logic             Branch_MEM,
    input  logic             Zero_MEM,
    input  logic             MemRead_MEM,
    input  logic             MemWrite_MEM,
    input  logic             dmem_ack,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic             Stall_All,
    output logic             dmem_req,
    output logic             mem_fault
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2**CNT_W) - 1 || PERF_W < 1) begin : g_bad_cfg
        $error("pipe_hazard_ctrl: illegal TIMEOUT_CYCLES/CNT_W/PERF_W");
    end

    ctrl_state_e      state;
    logic [CNT_W-1:0] wait_cnt;
    logic             loaduse;
    logic             taken;
    logic             memop;

    hazard_detect u_hazard_detect (
        .mem_read_ex (MemRead_EX),
        .rt_ex       (Rt_EX),
        .rs_id       (Rs_ID),
        .rt_id       (Rt_ID),
        .branch_mem  (Branch_MEM),
        .zero_mem    (Zero_MEM),
        .loaduse     (loaduse),
        .taken       (taken)
    );

    assign memop = is_memop(MemRead_MEM, MemWrite_MEM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (memop && !dmem_ack) begin
                        state    <= WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == TIMEOUT_C) begin
                        state <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                FAULT:   state <= FAULT;
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Stall has absolute priority: a frozen pipeline must not flush or bubble.
    always_comb begin
        PCWrite     = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;
        Stall_All   = 1'b0;
        dmem_req    = 1'b0;
        mem_fault   = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    dmem_req  = memop;
                    Stall_All = memop & ~dmem_ack;
                end
                WAIT: begin
                    dmem_req  = 1'b1;
                    Stall_All = ~dmem_ack;
                end
                FAULT: begin
                    Stall_All = 1'b1;
                    mem_fault = 1'b1;
                end
                default: ;
            endcase
            if (!Stall_All) begin
                if (taken) begin
                    IFID_Flush  = 1'b1;
                    IDEX_Flush  = 1'b1;
                    EXMEM_Flush = 1'b1;
                    PCWrite     = 1'b1;
                    IFID_Write  = 1'b1;
                end else if (loaduse) begin
                    IDEX_Bubble = 1'b1;
                end else begin
                    PCWrite    = 1'b1;
                    IFID_Write = 1'b1;
                end
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (Stall_All || IDEX_Bubble) stall_cycles <= sat_inc(stall_cycles);
            if (IFID_Flush)               flush_count  <= sat_inc(flush_count);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a behavioural reference model.
module tb_pipe_hazard_ctrl;

    localparam int TO     = 4;
    localparam int PERF_W = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       MemRead_EX;
    logic [4:0] Rt_EX, Rs_ID, Rt_ID;
    logic       Branch_MEM, Zero_MEM, MemRead_MEM, MemWrite_MEM, dmem_ack;
    logic       PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, EXMEM_Flush;
    logic       Stall_All, dmem_req, mem_fault;
`ifdef PIPE_HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cycles, flush_count;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5), .PERF_W(PERF_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .MemRead_EX   (MemRead_EX),
        .Rt_EX        (Rt_EX),
        .Rs_ID        (Rs_ID),
        .Rt_ID        (Rt_ID),
        .Branch_MEM   (Branch_MEM),
        .Zero_MEM     (Zero_MEM),
        .MemRead_MEM  (MemRead_MEM),
        .MemWrite_MEM (MemWrite_MEM),
        .dmem_ack     (dmem_ack),
        .PCWrite      (PCWrite),
        .IFID_Write   (IFID_Write),
        .IDEX_Bubble  (IDEX_Bubble),
        .IFID_Flush   (IFID_Flush),
        .IDEX_Flush   (IDEX_Flush),
        .EXMEM_Flush  (EXMEM_Flush),
        .Stall_All    (Stall_All),
        .dmem_req     (dmem_req),
        .mem_fault    (mem_fault)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: "waiting" = a memory access outstanding, "faulted" = core halted.
    bit waiting = 0, faulted = 0;
    int waited  = 0;
    int m_stall = 0, m_flush = 0;
    localparam int PERF_MAX = (1 << PERF_W) - 1;

    task automatic clr_in();
        reset = 0; MemRead_EX = 0; Rt_EX = 0; Rs_ID = 0; Rt_ID = 0;
        Branch_MEM = 0; Zero_MEM = 0; MemRead_MEM = 0; MemWrite_MEM = 0; dmem_ack = 0;
    endtask

    // Inputs are applied just after a rising edge; outputs are checked mid-cycle.
    task automatic step();
        bit memop, tk, lu, stall, req;
        bit e_pcw, e_ifw, e_bub, e_fl;
        #4;
        memop = MemRead_MEM || MemWrite_MEM;
        tk    = Branch_MEM && Zero_MEM;
        lu    = MemRead_EX && (Rt_EX != 0) && (Rt_EX == Rs_ID || Rt_EX == Rt_ID);
        req = 0; stall = 0; e_pcw = 0; e_ifw = 0; e_bub = 0; e_fl = 0;
        if (!reset) begin
            if (faulted)      begin req = 0;     stall = 1; end
            else if (waiting) begin req = 1;     stall = !dmem_ack; end
            else              begin req = memop; stall = memop && !dmem_ack; end
            if (!stall) begin
                if (tk)      begin e_fl = 1; e_pcw = 1; e_ifw = 1; end
                else if (lu) e_bub = 1;
                else         begin e_pcw = 1; e_ifw = 1; end
            end
        end
        chk("PCWrite",     PCWrite,     e_pcw);
        chk("IFID_Write",  IFID_Write,  e_ifw);
        chk("IDEX_Bubble", IDEX_Bubble, e_bub);
        chk("IFID_Flush",  IFID_Flush,  e_fl);
        chk("IDEX_Flush",  IDEX_Flush,  e_fl);
        chk("EXMEM_Flush", EXMEM_Flush, e_fl);
        chk("Stall_All",   Stall_All,   stall);
        chk("dmem_req",    dmem_req,    req);
        chk("mem_fault",   mem_fault,   faulted && !reset);
`ifdef PIPE_HAZARD_PERF_EN
        chk("stall_cycles", stall_cycles, m_stall);
        chk("flush_count",  flush_count,  m_flush);
`endif
        if (reset) begin
            waiting = 0; faulted = 0; waited = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (stall || e_bub) m_stall = (m_stall < PERF_MAX) ? m_stall + 1 : PERF_MAX;
            if (e_fl)           m_flush = (m_flush < PERF_MAX) ? m_flush + 1 : PERF_MAX;
            if (!faulted) begin
                if (waiting) begin
                    if (dmem_ack)         begin waiting = 0; waited = 0; end
                    else if (waited == TO) begin waiting = 0; faulted = 1; end
                    else                   waited++;
                end else if (memop && !dmem_ack) begin
                    waiting = 1; waited = 1;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        clr_in();
        reset = 1;
        @(posedge clk); #1;
        step(); step();
        chk("reset_PCWrite_low", PCWrite, 0);
        clr_in();
        step();
        // Load-use on rs, then the load moves on
        MemRead_EX = 1; Rt_EX = 5; Rs_ID = 5; step();
        clr_in(); step();
        // $zero destination never stalls
        MemRead_EX = 1; Rt_EX = 0; Rs_ID = 0; Rt_ID = 0; step();
        clr_in();
        // Taken branch wins over a simultaneous load-use
        MemRead_EX = 1; Rt_EX = 7; Rt_ID = 7; Branch_MEM = 1; Zero_MEM = 1; step();
        clr_in(); step();
        // 3-cycle memory wait then ack
        MemRead_MEM = 1;
        repeat (3) step();
        dmem_ack = 1; step();
        clr_in(); step();
        // Zero-wait store
        MemWrite_MEM = 1; dmem_ack = 1; step();
        clr_in(); step();
        // Timeout into FAULT, sticky until reset
        MemRead_MEM = 1;
        repeat (TO + 1) step();
        repeat (3) step();
        chk("fault_sticky", mem_fault, 1);
        dmem_ack = 1; step();
        reset = 1; step();
        clr_in(); step();
        chk("fault_cleared", mem_fault, 0);
        // Reset mid-WAIT, then a stray ack with no memop
        MemRead_MEM = 1; step(); step();
        reset = 1; step();
        clr_in(); dmem_ack = 1; step();
        clr_in(); step();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            reset        = ($urandom_range(0, 24) == 0);
            MemRead_EX   = 1'($urandom_range(0, 1));
            Rt_EX        = 5'($urandom_range(0, 3));
            Rs_ID        = 5'($urandom_range(0, 3));
            Rt_ID        = 5'($urandom_range(0, 3));
            Branch_MEM   = 1'($urandom_range(0, 1));
            Zero_MEM     = 1'($urandom_range(0, 1));
            MemRead_MEM  = ($urandom_range(0, 3) == 0);
            MemWrite_MEM = ($urandom_range(0, 3) == 0);
            dmem_ack     = 1'($urandom_range(0, 1));
            step();
        end
        // Long stall run drives the narrow perf counter into saturation
        clr_in(); reset = 1; step();
        clr_in(); MemRead_MEM = 1;
        repeat (TO + 25) step();
        clr_in(); reset = 1; step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
